// File: rtl/wishbone_interconnect.sv
// Single-master, N-slave bus interconnect with base/mask address decode and error on unmapped access.
// Optional bus-timeout watchdog: define WB_INTERCONNECT_TIMEOUT_EN.
module wishbone_interconnect #(
  parameter int                              NUM_SLAVES     = 2,
  parameter int                              ADDR_SIZE      = 64,
  parameter int                              DATA_SIZE      = 64,
  parameter int                              SEL_SIZE       = DATA_SIZE / 8,
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_BASE     = {64'h0100_0000, 64'h0},
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_MASK     = {64'hFF00_0000, 64'hFF00_0000},
  parameter int                              TIMEOUT_CYCLES = 64
) (
  input  logic                           CLK_I,
  input  logic                           RST_I,
  input  logic                           CYC_I,
  input  logic                           STB_I,
  input  logic                           WE_I,
  input  logic [SEL_SIZE-1:0]            SEL_I,
  input  logic [ADDR_SIZE-1:0]           ADR_I,
  input  logic [DATA_SIZE-1:0]           DAT_I,
  output logic [DATA_SIZE-1:0]           DAT_O,
  output logic                           ACK_O,
  output logic                           ERR_O,
  output logic [NUM_SLAVES-1:0]          s_CYC_O,
  output logic [NUM_SLAVES-1:0]          s_STB_O,
  output logic                           s_WE_O,
  output logic [SEL_SIZE-1:0]            s_SEL_O,
  output logic [ADDR_SIZE-1:0]           s_ADR_O,
  output logic [DATA_SIZE-1:0]           s_DAT_O,
  input  logic [NUM_SLAVES*DATA_SIZE-1:0] s_DAT_I,
  input  logic [NUM_SLAVES-1:0]          s_ACK_I
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1 || (DATA_SIZE % 8) != 0) begin : g_bad_params
    $error("wishbone_interconnect: illegal parameter combination");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t                  state;
  state_t                  next_state;
  logic                    hit_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [DATA_SIZE-1:0]    rd_data;
  logic                    slave_ack;
  logic                    timed_out;
  logic [NUM_SLAVES-1:0]   onehot;
  logic                    capture;
  logic                    launch;
  logic                    drop;
  logic                    do_ack;
  logic                    do_err;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((ADR_I & SLAVE_MASK[i*ADDR_SIZE +: ADDR_SIZE]) == SLAVE_BASE[i*ADDR_SIZE +: ADDR_SIZE]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rd_data   = '0;
    slave_ack = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_data   = s_DAT_I[i*DATA_SIZE +: DATA_SIZE];
        slave_ack = s_ACK_I[i];
      end
    end
  end

  assign onehot = NUM_SLAVES'(1) << idx_q;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles; the last one without an ACK trips the watchdog.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wait_cnt <= '0;
    end else if (launch) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timed_out = (state == ST_WAIT) && (wait_cnt == CNT_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Abort beats a same-cycle ACK, and ACK beats a same-cycle timeout.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    launch     = 1'b0;
    drop       = 1'b0;
    do_ack     = 1'b0;
    do_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (CYC_I && STB_I) begin
          capture    = 1'b1;
          next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!CYC_I) begin
          next_state = ST_IDLE;
        end else if (hit_q) begin
          launch     = 1'b1;
          next_state = ST_WAIT;
        end else begin
          do_err     = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!CYC_I) begin
          drop       = 1'b1;
          next_state = ST_IDLE;
        end else if (slave_ack) begin
          drop       = 1'b1;
          do_ack     = 1'b1;
          next_state = ST_RESP;
        end else if (timed_out) begin
          drop       = 1'b1;
          do_err     = 1'b1;
          next_state = ST_RESP;
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      DAT_O   <= '0;
      ACK_O   <= 1'b0;
      ERR_O   <= 1'b0;
      s_CYC_O <= '0;
      s_STB_O <= '0;
      s_WE_O  <= 1'b0;
      s_SEL_O <= '0;
      s_ADR_O <= '0;
      s_DAT_O <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      ACK_O <= do_ack;
      ERR_O <= do_err;
      if (capture) begin
        s_WE_O  <= WE_I;
        s_SEL_O <= SEL_I;
        s_ADR_O <= ADR_I;
        s_DAT_O <= DAT_I;
        hit_q   <= dec_hit;
        idx_q   <= dec_idx;
      end
      if (launch) begin
        s_CYC_O <= onehot;
        s_STB_O <= onehot;
      end else if (drop) begin
        s_CYC_O <= '0;
        s_STB_O <= '0;
      end
      if (do_ack && !s_WE_O) DAT_O <= rd_data;
    end
  end

endmodule
